access_lockout_ctrl: RTL and testbench
======================================

// Module: access_lockout_ctrl
// PURPOSE
//  Parametrised key-check access controller with retry limit and timed lockout.
//  Accepts a KEY_W-bit key over a valid/ready handshake. Grants access when the key is non-zero with an
//  even population count, for a fixed window. After MAX_TRIES consecutive failures it locks out for a fixed time.
//  Sits between the keypad/decoder front end and the door/actuator driver.
// PARAMETERS
//  KEY_W        8   key width in bits (>=2)
//  MAX_TRIES    3   consecutive failed checks that trigger lockout (>=1)
//  GRANT_CYCLES 4   cycles access_granted stays high per pass (>=1)
//  LOCK_CYCLES  16  cycles spent in lockout (>=1)
// PORTS
//  clk            in   1                     clock, rising edge
//  rst            in   1                     reset, asynchronous, active-high
//  key            in   KEY_W                 candidate key
//  key_valid      in   1                     key is presented
//  key_ready      out  1                     block accepts a key this cycle
//  lock_clr       in   1                     sync admin override: LOCKED->IDLE, clears tries
//  access_granted out  1                     high during the grant window
//  access_denied  out  1                     one-cycle pulse on a non-locking failure
//  locked         out  1                     high during lockout
//  try_count      out  $clog2(MAX_TRIES+1)   current consecutive-failure count
// BEHAVIOUR
//  - rst is asynchronous: state goes to IDLE. All outputs are 0 except key_ready=1, and try_count=0.
//    rst asserted mid-grant or mid-lockout aborts it immediately.
//  - FSM states IDLE, CHECK, GRANT, DENY, LOCKED. All outputs decode from registered state/counters (no comb path from inputs).
//  - key_ready = (state==IDLE). A key is accepted when key_valid && key_ready at a clock edge.
//    The key is registered on accept. key_valid outside IDLE is ignored, not queued.
//  - IDLE --accept--> CHECK. CHECK lasts exactly 1 cycle.
//  - Pass rule: reg_key != 0 and popcount(reg_key) even. Zero key always fails.
//  - CHECK pass -> GRANT. try_count<=0. Timer loads GRANT_CYCLES. access_granted=1 for exactly GRANT_CYCLES cycles, then IDLE.
//  - CHECK fail, try_count+1 < MAX_TRIES -> DENY for 1 cycle (access_denied=1), try_count increments, then IDLE.
//  - CHECK fail, try_count+1 == MAX_TRIES -> LOCKED. No DENY pulse. try_count holds MAX_TRIES.
//    locked=1 for exactly LOCK_CYCLES cycles. On exit to IDLE, try_count<=0.
//  - Latency: accept edge at cycle n. Outcome output is high from cycle n+2.
//    After GRANT or DENY ends, key_ready returns the next cycle.
//  - lock_clr is honoured only in LOCKED: next state IDLE, try_count<=0. It is ignored in all other states.
//  - Timer width is $clog2(max(GRANT_CYCLES,LOCK_CYCLES)+1). Timer counts down to 1 and never wraps.
//    try_count saturates at MAX_TRIES.
// CONFIGURATION
//  ACCESS_FAIL_CNT_EN defined: adds port fail_total (out, 16) = total failed checks since rst.
//    Increments once per failing CHECK, including the one that locks. Saturates at 16'hFFFF. Reset value 0.
//  ACCESS_FAIL_CNT_EN undefined: the port and its counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package access_pkg holds: state enum typedef access_state_t, and function popcount_even(key) parametrised by width.
//  - One sub-module, key_parity_chk: combinational KEY_W-input nonzero/even-parity checker.
//    It is instantiated once on reg_key. FSM, timer and try counter stay in this module.
// TESTING
//  1. Reset: rst pulse mid-GRANT -> access_granted=0 and key_ready=1 immediately (async), try_count=0.
//  2. Pass: key=8'h03, valid at cycle 0 -> access_granted=1 on cycles 2..5. key_ready=1 at cycle 6.
//  3. Fail: key=8'h07 -> access_denied=1 only at cycle 2, try_count=1. Then key=8'h00 -> denied, try_count=2.
//  4. Lockout: three keys 8'h01 -> third gives no denied pulse. locked=1 for 16 cycles, key_ready=0, try_count=0 after.
//  5. Override: lock_clr=1 at lockout cycle 5 -> next cycle locked=0, key_ready=1. lock_clr in IDLE is no-op.
//  6. Recovery: two fails then key=8'hF0 -> grant, try_count=0. With ACCESS_FAIL_CNT_EN, fail_total=2.

Source files
------------

// File: rtl/access_pkg.sv
// Shared types and helpers for the access lockout controller.
// popcount_even zero-extends narrower keys; padding zeros do not change parity.
package access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_GRANT,
    ST_DENY,
    ST_LOCKED
  } access_state_t;

  // Widest key the parity helper handles.
  localparam int KEY_PAD_W = 64;

  function automatic logic popcount_even(input logic [KEY_PAD_W-1:0] key);
    return ~^key;
  endfunction

endpackage

// File: rtl/key_parity_chk.sv
// Combinational key checker: passes a non-zero key with even population count.
// Zero latency, no flow control; KEY_W must not exceed access_pkg::KEY_PAD_W.
module key_parity_chk
  import access_pkg::*;
#(
  parameter int KEY_W = 8
) (
  input  logic [KEY_W-1:0] key_i,
  output logic             pass_o
);

  assign pass_o = (|key_i) && popcount_even(KEY_PAD_W'(key_i));

endmodule

// File: rtl/access_lockout_ctrl.sv
// Key-check access controller with retry limit and timed lockout; outcome 2 cycles after accept.
// key_ready only in IDLE (no queueing); optional fail_total counter under ACCESS_FAIL_CNT_EN.
module access_lockout_ctrl
  import access_pkg::*;
#(
  parameter int KEY_W        = 8,
  parameter int MAX_TRIES    = 3,
  parameter int GRANT_CYCLES = 4,
  parameter int LOCK_CYCLES  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [KEY_W-1:0]               key,
  input  logic                           key_valid,
  output logic                           key_ready,
  input  logic                           lock_clr,
  output logic                           access_granted,
  output logic                           access_denied,
  output logic                           locked,
`ifdef ACCESS_FAIL_CNT_EN
  output logic [15:0]                    fail_total,
`endif
  output logic [$clog2(MAX_TRIES+1)-1:0] try_count
);

  localparam int TMAX = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(MAX_TRIES + 1);

  localparam logic [TW-1:0] GRANT_LD  = TW'(GRANT_CYCLES);
  localparam logic [TW-1:0] LOCK_LD   = TW'(LOCK_CYCLES);
  localparam logic [CW-1:0] TRIES_MAX = CW'(MAX_TRIES);
  localparam logic [CW-1:0] TRIES_PRE = CW'(MAX_TRIES - 1);

  access_state_t    state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    try_q, try_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_pass;

  key_parity_chk #(
    .KEY_W (KEY_W)
  ) u_chk (
    .key_i  (key_q),
    .pass_o (key_pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      try_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      try_q   <= try_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    try_d   = try_q;
    key_d   = key_q;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          key_d   = key;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (key_pass) begin
          state_d = ST_GRANT;
          timer_d = GRANT_LD;
          try_d   = '0;
        end else if (try_q < TRIES_PRE) begin
          state_d = ST_DENY;
          try_d   = try_q + CW'(1);
        end else begin
          // Final allowed failure locks out silently, without a deny pulse.
          state_d = ST_LOCKED;
          timer_d = LOCK_LD;
          try_d   = TRIES_MAX;
        end
      end
      ST_GRANT: begin
        if (timer_q <= TW'(1)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_DENY: begin
        state_d = ST_IDLE;
      end
      ST_LOCKED: begin
        if (lock_clr || timer_q <= TW'(1)) begin
          state_d = ST_IDLE;
          timer_d = '0;
          try_d   = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        try_d   = '0;
      end
    endcase
  end

  assign key_ready      = (state_q == ST_IDLE);
  assign access_granted = (state_q == ST_GRANT);
  assign access_denied  = (state_q == ST_DENY);
  assign locked         = (state_q == ST_LOCKED);
  assign try_count      = try_q;

`ifdef ACCESS_FAIL_CNT_EN
  logic [15:0] fail_q, fail_d;

  assign fail_d = (state_q == ST_CHECK && !key_pass && fail_q != 16'hFFFF)
                ? fail_q + 16'd1 : fail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q <= '0;
    end else begin
      fail_q <= fail_d;
    end
  end

  assign fail_total = fail_q;
`endif

endmodule

// File: tb/tb_access_lockout_ctrl.sv
// Scoreboard bench for access_lockout_ctrl: directed keys push expected outcome cycles,
// a negedge monitor pops and compares whenever granted/denied/locked is presented.
module tb_access_lockout_ctrl;

  localparam int KEY_W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key = '0;
  logic       key_valid = 1'b0;
  logic       lock_clr = 1'b0;
  logic       key_ready, access_granted, access_denied, locked;
  logic [1:0] try_count;
`ifdef ACCESS_FAIL_CNT_EN
  logic [15:0] fail_total;
`endif

  access_lockout_ctrl #(
    .KEY_W        (KEY_W),
    .MAX_TRIES    (3),
    .GRANT_CYCLES (4),
    .LOCK_CYCLES  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key            (key),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .lock_clr       (lock_clr),
    .access_granted (access_granted),
    .access_denied  (access_denied),
    .locked         (locked),
`ifdef ACCESS_FAIL_CNT_EN
    .fail_total     (fail_total),
`endif
    .try_count      (try_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       g;
    logic       d;
    logic       l;
    logic [1:0] tc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_out(input int c0, input int n, input logic g, input logic d,
                            input logic l, input logic [1:0] tc);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.c = c0 + i; e.g = g; e.d = d; e.l = l; e.tc = tc;
      sb.push_back(e);
    end
  endtask

  // Monitor: every presented outcome cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (access_granted || access_denied || locked)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: cycle %0d g=%b d=%b l=%b, expected no output",
                 cyc, access_granted, access_denied, locked);
      end else begin
        e = sb.pop_front();
        check("out_cycle", cyc, e.c);
        check("out_gdl", {29'd0, access_granted, access_denied, locked}, {29'd0, e.g, e.d, e.l});
        check("out_try", {30'd0, try_count}, {30'd0, e.tc});
      end
    end
  end

  task automatic submit(input logic [7:0] k, output int a);
    @(negedge clk);
    key       = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    a         = cyc;
    key_valid = 1'b0;
    key       = '0;
  endtask

  task automatic wait_ready(input string name, input int exp_c);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (key_ready) break;
    end
    check(name, key_ready ? cyc : -1, exp_c);
  endtask

  task automatic fail_once(input logic [7:0] k, input logic [1:0] tc);
    int a;
    submit(k, a);
    expect_out(a + 1, 1, 1'b0, 1'b1, 1'b0, tc);
    wait_ready("deny_ready", a + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    repeat (2) @(negedge clk);
    check("rst_key_ready", key_ready, 1);
    check("rst_granted", access_granted, 0);
    check("rst_denied", access_denied, 0);
    check("rst_locked", locked, 0);
    check("rst_try", try_count, 0);
    rst = 1'b0;

    // Reset mid-grant aborts immediately.
    submit(8'h03, a);
    expect_out(a + 1, 2, 1'b1, 1'b0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_granted", access_granted, 0);
    check("async_rst_ready", key_ready, 1);
    check("async_rst_try", try_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Pass: four grant cycles, ready the cycle after.
    submit(8'h03, a);
    expect_out(a + 1, 4, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_ready("pass_ready", a + 5);

    // Two failures, then recovery with an even-parity key.
    fail_once(8'h07, 2'd1);
    fail_once(8'h00, 2'd2);
    check("try_after_two", try_count, 2);
    submit(8'hF0, a);
    expect_out(a + 1, 4, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_ready("recover_ready", a + 5);
    check("recover_try", try_count, 0);
`ifdef ACCESS_FAIL_CNT_EN
    check("fail_total_2", fail_total, 2);
`endif

    // Lockout after three failures: no deny pulse on the third.
    fail_once(8'h01, 2'd1);
    fail_once(8'h01, 2'd2);
    submit(8'h01, a);
    expect_out(a + 1, 16, 1'b0, 1'b0, 1'b1, 2'd3);
    wait_ready("lock_ready", a + 17);
    check("lock_exit_try", try_count, 0);
`ifdef ACCESS_FAIL_CNT_EN
    check("fail_total_5", fail_total, 5);
`endif

    // Admin override at lockout cycle 5.
    fail_once(8'h01, 2'd1);
    fail_once(8'h01, 2'd2);
    submit(8'h01, a);
    expect_out(a + 1, 5, 1'b0, 1'b0, 1'b1, 2'd3);
    repeat (6) @(negedge clk);
    #1 lock_clr = 1'b1;
    @(posedge clk);
    #1 lock_clr = 1'b0;
    wait_ready("clr_ready", a + 6);
    check("clr_locked", locked, 0);
    check("clr_try", try_count, 0);

    // lock_clr outside lockout leaves the try count alone.
    fail_once(8'h07, 2'd1);
    @(negedge clk);
    lock_clr = 1'b1;
    @(posedge clk);
    #1 lock_clr = 1'b0;
    @(negedge clk);
    check("idle_clr_try", try_count, 1);
    check("idle_clr_ready", key_ready, 1);
    check("idle_clr_locked", locked, 0);
`ifdef ACCESS_FAIL_CNT_EN
    check("fail_total_9", fail_total, 9);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
